// File: rtl/cs_1035_up.sv
// cs_1035_up: LOW..HIGH up counter with enable, preset, range-checked load,
// terminal-count/wrap/error flags and registered BCD digits of the count.
module cs_1035_up #(
   parameter int unsigned W    = 6,
   parameter int unsigned LOW  = 10,
   parameter int unsigned HIGH = 35
) (
   input  logic         clk,
   input  logic         CLR,
   input  logic         PR,
   input  logic         EN,
   input  logic         LD,
   input  logic [W-1:0] D,
   output logic [W-1:0] Q,
   output logic         TC,
   output logic         WRAP,
   output logic         ERR,
   output logic [3:0]   TENS,
   output logic [3:0]   UNITS
);

   localparam logic [W-1:0] LOW_V     = W'(LOW);
   localparam logic [W-1:0] HIGH_V    = W'(HIGH);
   localparam logic [W-1:0] TEN_V     = W'(10);
   localparam logic [3:0]   LOW_TENS  = 4'(LOW / 10);
   localparam logic [3:0]   LOW_UNITS = 4'(LOW % 10);

   logic [W-1:0] q_q, q_d;
   logic         wrap_q, wrap_d;
   logic         err_q, err_d;
   logic [3:0]   tens_q, tens_d;
   logic [3:0]   units_q, units_d;

   // Next count and flags: preset > load > count > hold; BCD from next count
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      if (!PR) begin
         q_d = HIGH_V;
      end else if (LD) begin
         if ((D >= LOW_V) && (D <= HIGH_V)) begin
            q_d = D;
         end else begin
            q_d   = LOW_V;
            err_d = 1'b1;
         end
      end else if (EN) begin
         if (q_q == HIGH_V) begin
            q_d    = LOW_V;
            wrap_d = 1'b1;
         end else if ((q_q < LOW_V) || (q_q > HIGH_V)) begin
            // out-of-range count recovers silently, no wrap pulse
            q_d = LOW_V;
         end else begin
            q_d = q_q + W'(1);
         end
      end
      tens_d  = 4'(q_d / TEN_V);
      units_d = 4'(q_d % TEN_V);
   end

   // State registers with asynchronous reset to LOW
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         q_q     <= LOW_V;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
         tens_q  <= LOW_TENS;
         units_q <= LOW_UNITS;
      end else begin
         q_q     <= q_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

   assign Q     = q_q;
   assign TC    = (q_q == HIGH_V);
   assign WRAP  = wrap_q;
   assign ERR   = err_q;
   assign TENS  = tens_q;
   assign UNITS = units_q;

endmodule
